// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-side definitions: RV32I major opcodes, fetch FSM encoding
// and the instruction word width.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    function automatic logic is_system(input logic [INSTR_W-1:0] instr);
        return instr[6:0] == OPC_SYSTEM;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous response FIFO holding {pc, instr}; head is read straight
// from storage and forced to zero while empty.
module fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC sequencer, single outstanding imem read per cycle,
// response FIFO toward decode, redirect flush and halt on SYSTEM.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int               ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;

    fetch_state_e        state;
    fetch_state_e        state_nxt;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   inflight_pc;
    logic                inflight;
    logic [CW-1:0]       count;
    logic                pop;
    logic                push;
    logic                space_ok;
    logic [OW-1:0]       occ;
    logic [OW-1:0]       lim;
    logic [ADDR_W-1:0]   redirect_addr;
    logic [ADDR_W+INSTR_W-1:0] head;

    assign redirect_addr = redirect_pc & ~ADDR_W'(3);
    assign instr_valid   = (count != '0);
    assign pop           = instr_valid & instr_ready;
    assign {pc_out, instr_out} = head;
    assign halted        = (state == ST_HALT);

    // Room must cover the word already in flight; a same-cycle pop frees a slot.
    assign occ      = OW'(count) + OW'(inflight);
    assign lim      = OW'(FIFO_DEPTH) + OW'(pop);
    assign space_ok = (occ < lim);

    // Responses landing outside RUN belong to a fetch past SYSTEM.
    assign push = inflight & (state == ST_RUN) & ~redirect_valid;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        if (reset) begin
            state_nxt = ST_IDLE;
        end else if (redirect_valid) begin
            state_nxt = ST_RUN;
            imem_req  = 1'b1;
            imem_addr = redirect_addr;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    imem_req = space_ok;
                    if (push && is_system(imem_rdata)) state_nxt = ST_HALT;
                end
                ST_HALT: begin
                    state_nxt = ST_HALT;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= imem_addr;
                fetch_pc    <= imem_addr + ADDR_W'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (ADDR_W + INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata ({inflight_pc, imem_rdata}),
        .rdata (head),
        .count (count)
    );

endmodule
